// File: rtl/player_motion_if.sv
// Player motion bus: frame strobe and debounced buttons from the game engine,
// registered position/velocity/state back to the engine.
//   master : engine side (drives strobe and buttons, observes motion outputs)
//   slave  : player_motion side
interface player_motion_if;
   logic       gameSCEN;
   logic       debouncedBtnU;
   logic       debouncedBtnL;
   logic       debouncedBtnR;
   logic [9:0] playerX;
   logic [9:0] playerY;
   logic [5:0] velY;
   logic [1:0] motionState;
   logic       airborne;
   logic       frameDone;

   modport master (
      output gameSCEN, debouncedBtnU, debouncedBtnL, debouncedBtnR,
      input  playerX, playerY, velY, motionState, airborne, frameDone
   );

   modport slave (
      input  gameSCEN, debouncedBtnU, debouncedBtnL, debouncedBtnR,
      output playerX, playerY, velY, motionState, airborne, frameDone
   );
endinterface

// File: rtl/player_motion.sv
// Player motion controller: per-frame jump/gravity integration on y with
// floor/ceiling clamping, held-button stepping on x with bound clamping.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : player_motion_if.slave
//          in  gameSCEN (frame strobe), debouncedBtnU/L/R
//          out playerX, playerY, velY (signed), motionState, airborne,
//              frameDone (one cycle after each frame update)
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_GROUNDED  | resting on GROUND_Y, velY = 0, a jump request launches
// ST_RISING    | airborne, velY < 0 (moving up the screen)
// ST_FALLING   | airborne, velY >= 0 (apex reached or ceiling hit)
// 2'b11        | illegal, recovers to grounded on the next frame
module player_motion #(
   parameter int GROUND_Y = 400,
   parameter int TOP_Y    = 40,
   parameter int JUMP_V   = 12,
   parameter int GRAVITY  = 1,
   parameter int MAX_FALL = 8,
   parameter int X_MIN    = 0,
   parameter int X_MAX    = 600,
   parameter int X_START  = 300,
   parameter int X_STEP   = 4
) (
   input  logic            clk,
   input  logic            rst,
   player_motion_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_GROUNDED = 2'b00,
      ST_RISING   = 2'b01,
      ST_FALLING  = 2'b10
   } state_t;

   localparam logic [9:0]        GROUND_Y_10 = 10'(GROUND_Y);
   localparam logic [9:0]        TOP_Y_10    = 10'(TOP_Y);
   localparam logic [9:0]        JUMP_V_10   = 10'(JUMP_V);
   localparam logic [9:0]        X_MIN_10    = 10'(X_MIN);
   localparam logic [9:0]        X_MAX_10    = 10'(X_MAX);
   localparam logic [9:0]        X_START_10  = 10'(X_START);
   localparam logic signed [10:0] GROUND_Y_S = 11'(GROUND_Y);
   localparam logic signed [10:0] TOP_Y_S    = 11'(TOP_Y);
   localparam logic signed [10:0] GRAVITY_S  = 11'(GRAVITY);
   localparam logic signed [10:0] MAX_FALL_S = 11'(MAX_FALL);
   localparam logic signed [10:0] X_MIN_S    = 11'(X_MIN);
   localparam logic signed [10:0] X_MAX_S    = 11'(X_MAX);
   localparam logic signed [10:0] X_STEP_S   = 11'(X_STEP);
   // Launch frame already applies one frame of gravity.
   localparam logic signed [5:0]  LAUNCH_V   = 6'(GRAVITY - JUMP_V);

   state_t             state_q, state_d;
   logic [9:0]         x_q, x_d;
   logic [9:0]         y_q, y_d;
   logic signed [5:0]  vel_q, vel_d;
   logic               jump_pending_q, jump_pending_d;
   logic               frame_done_q, frame_done_d;

   logic               jump_req;
   logic signed [10:0] vel_ext;
   logic signed [10:0] new_y;
   logic signed [10:0] vel_plus;
   logic signed [10:0] new_v;
   logic signed [10:0] x_left;
   logic signed [10:0] x_right;

   // A button press in the strobe cycle itself counts for that frame.
   assign jump_req = jump_pending_q | bus.debouncedBtnU;

   // 11-bit signed sums so crossings past either y bound stay visible.
   assign vel_ext  = {{5{vel_q[5]}}, vel_q};
   assign new_y    = $signed({1'b0, y_q}) + vel_ext;
   assign vel_plus = vel_ext + GRAVITY_S;
   assign new_v    = (vel_plus > MAX_FALL_S) ? MAX_FALL_S : vel_plus;
   assign x_left   = $signed({1'b0, x_q}) - X_STEP_S;
   assign x_right  = $signed({1'b0, x_q}) + X_STEP_S;

   always_comb begin
      state_d        = state_q;
      x_d            = x_q;
      y_d            = y_q;
      vel_d          = vel_q;
      jump_pending_d = jump_pending_q | bus.debouncedBtnU;
      frame_done_d   = bus.gameSCEN;

      if (bus.gameSCEN) begin
         // No buffering: a request not taken this frame is dropped.
         jump_pending_d = 1'b0;

         if (bus.debouncedBtnL && !bus.debouncedBtnR) begin
            x_d = (x_left < X_MIN_S) ? X_MIN_10 : x_left[9:0];
         end else if (bus.debouncedBtnR && !bus.debouncedBtnL) begin
            x_d = (x_right > X_MAX_S) ? X_MAX_10 : x_right[9:0];
         end

         case (state_q)
            ST_GROUNDED: begin
               if (jump_req) begin
                  y_d     = y_q - JUMP_V_10;
                  vel_d   = LAUNCH_V;
                  state_d = ST_RISING;
               end
            end
            ST_RISING, ST_FALLING: begin
               if (new_y >= GROUND_Y_S) begin
                  y_d     = GROUND_Y_10;
                  vel_d   = '0;
                  state_d = ST_GROUNDED;
               end else if (new_y < TOP_Y_S) begin
                  y_d     = TOP_Y_10;
                  vel_d   = '0;
                  state_d = ST_FALLING;
               end else begin
                  y_d     = new_y[9:0];
                  vel_d   = new_v[5:0];
                  state_d = new_v[10] ? ST_RISING : ST_FALLING;
               end
            end
            default: begin
               y_d     = GROUND_Y_10;
               vel_d   = '0;
               state_d = ST_GROUNDED;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_GROUNDED;
         x_q            <= X_START_10;
         y_q            <= GROUND_Y_10;
         vel_q          <= '0;
         jump_pending_q <= 1'b0;
         frame_done_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         x_q            <= x_d;
         y_q            <= y_d;
         vel_q          <= vel_d;
         jump_pending_q <= jump_pending_d;
         frame_done_q   <= frame_done_d;
      end
   end

   assign bus.playerX     = x_q;
   assign bus.playerY     = y_q;
   assign bus.velY        = vel_q;
   assign bus.motionState = state_q;
   assign bus.airborne    = (state_q != ST_GROUNDED);
   assign bus.frameDone   = frame_done_q;

endmodule

// File: tb/tb_player_motion.sv
// Directed bench for player_motion: jump arc, jump request timing, horizontal
// clamping, reset priority and frame strobe accounting.
module tb_player_motion;

   logic clk = 1'b0;
   logic rst;

   player_motion_if pm_if();

   player_motion dut (
      .clk (clk),
      .rst (rst),
      .bus (pm_if)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int sc_cnt  = 0;
   int fd_cnt  = 0;

   // Frame strobes accepted (not masked by reset) vs frameDone pulses seen.
   always @(posedge clk) begin
      if (pm_if.gameSCEN && !rst) sc_cnt++;
      if (pm_if.frameDone)        fd_cnt++;
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk_pos(input string tag, input int x, input int y, input int v, input int st);
      chk({tag, ".x"},   int'(pm_if.playerX), x);
      chk({tag, ".y"},   int'(pm_if.playerY), y);
      chk({tag, ".v"},   int'($signed(pm_if.velY)), v);
      chk({tag, ".st"},  int'(pm_if.motionState), st);
      chk({tag, ".air"}, int'(pm_if.airborne), (st != 0) ? 1 : 0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_frame(input logic u);
      pm_if.gameSCEN      = 1'b1;
      pm_if.debouncedBtnU = u;
      tick();
      pm_if.gameSCEN      = 1'b0;
      pm_if.debouncedBtnU = 1'b0;
   endtask

   task automatic run_frames(input int n);
      for (int i = 0; i < n; i++) begin
         do_frame(1'b0);
         tick();
      end
   endtask

   initial begin
      rst                 = 1'b1;
      pm_if.gameSCEN      = 1'b0;
      pm_if.debouncedBtnU = 1'b0;
      pm_if.debouncedBtnL = 1'b0;
      pm_if.debouncedBtnR = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      chk_pos("reset", 300, 400, 0, 0);
      chk("reset.fd", int'(pm_if.frameDone), 0);

      // Grounded frame without request holds y.
      do_frame(1'b0);
      chk_pos("idle_frame", 300, 400, 0, 0);
      chk("idle_frame.fd", int'(pm_if.frameDone), 1);
      tick();
      chk("idle_frame.fd_low", int'(pm_if.frameDone), 0);

      // Jump pulse between frames, taken on the next frame.
      pm_if.debouncedBtnU = 1'b1;
      tick();
      pm_if.debouncedBtnU = 1'b0;
      tick();
      chk_pos("pend_hold", 300, 400, 0, 0);
      do_frame(1'b0);
      chk_pos("jump_f1", 300, 388, -11, 1);
      tick();
      for (int f = 2; f <= 26; f++) begin
         if (f == 4) begin
            // Request while rising must not relaunch.
            pm_if.debouncedBtnU = 1'b1;
            tick();
            pm_if.debouncedBtnU = 1'b0;
         end
         do_frame(1'b0);
         if (f == 2)  chk_pos("jump_f2", 300, 377, -10, 1);
         if (f == 4)  chk_pos("jump_f4", 300, 358, -8, 1);
         if (f == 12) chk_pos("jump_f12", 300, 322, 0, 2);
         if (f == 13) chk_pos("jump_f13", 300, 322, 1, 2);
         if (f == 21) chk_pos("jump_f21", 300, 358, 8, 2);
         if (f == 26) chk_pos("jump_f26", 300, 398, 8, 2);
         tick();
      end
      // Landing frame with a request in the same cycle: ignored, then dropped.
      do_frame(1'b1);
      chk_pos("land", 300, 400, 0, 0);
      tick();
      do_frame(1'b0);
      chk_pos("after_land", 300, 400, 0, 0);
      tick();

      // Request coincident with the frame strobe.
      do_frame(1'b1);
      chk_pos("same_cycle", 300, 388, -11, 1);
      tick();
      run_frames(26);
      chk_pos("land2", 300, 400, 0, 0);

      // Request one cycle after a frame applies only to the following frame.
      do_frame(1'b0);
      pm_if.debouncedBtnU = 1'b1;
      tick();
      pm_if.debouncedBtnU = 1'b0;
      chk_pos("late_pulse_hold", 300, 400, 0, 0);
      tick();
      do_frame(1'b0);
      chk_pos("late_pulse_jump", 300, 388, -11, 1);
      tick();
      run_frames(26);
      chk_pos("land3", 300, 400, 0, 0);

      // Right held: 75 frames to the right bound, then clamped.
      pm_if.debouncedBtnR = 1'b1;
      for (int f = 1; f <= 80; f++) begin
         do_frame(1'b0);
         if (f == 1)  chk("right_f1", int'(pm_if.playerX), 304);
         if (f == 74) chk("right_f74", int'(pm_if.playerX), 596);
         if (f == 75) chk("right_f75", int'(pm_if.playerX), 600);
         if (f == 80) chk("right_f80", int'(pm_if.playerX), 600);
         tick();
      end
      pm_if.debouncedBtnL = 1'b1;
      do_frame(1'b0);
      chk("both_held", int'(pm_if.playerX), 600);
      tick();
      pm_if.debouncedBtnR = 1'b0;
      for (int f = 1; f <= 155; f++) begin
         do_frame(1'b0);
         if (f == 1)   chk("left_f1", int'(pm_if.playerX), 596);
         if (f == 149) chk("left_f149", int'(pm_if.playerX), 4);
         if (f == 150) chk("left_f150", int'(pm_if.playerX), 0);
         if (f == 155) chk("left_f155", int'(pm_if.playerX), 0);
         tick();
      end
      pm_if.debouncedBtnL = 1'b0;

      // Horizontal and vertical in the same frame.
      pm_if.debouncedBtnR = 1'b1;
      do_frame(1'b1);
      chk_pos("jump_right_f1", 4, 388, -11, 1);
      tick();
      do_frame(1'b0);
      chk_pos("jump_right_f2", 8, 377, -10, 1);

      // Reset coincident with strobe and buttons while airborne.
      rst                 = 1'b1;
      pm_if.gameSCEN      = 1'b1;
      pm_if.debouncedBtnU = 1'b1;
      tick();
      rst                 = 1'b0;
      pm_if.gameSCEN      = 1'b0;
      pm_if.debouncedBtnU = 1'b0;
      pm_if.debouncedBtnR = 1'b0;
      chk_pos("rst_mid_jump", 300, 400, 0, 0);
      chk("rst_mid_jump.fd", int'(pm_if.frameDone), 0);
      tick();
      do_frame(1'b0);
      chk_pos("post_rst_frame", 300, 400, 0, 0);

      // No frameDone without a strobe.
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("idle_fd", int'(pm_if.frameDone), 0);
      end
      chk("fd_count", fd_cnt, sc_cnt);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
